spi_slave: RTL and testbench

- SPI target (slave) endpoint, SPI mode 3 (CPOL=1, CPHA=1), MSB first, 8-bit frames, own chip-select input.
- Sits on the far end of the team's SPI master link (on-chip loopback, board-to-board link, or flash-model bench).
- Oversamples spi_clk/spi_csn/spi_mosi in the sys_clk domain, deserialises received bytes and serialises a one-entry transmit buffer onto spi_miso.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave.sv | 136 +++++++++++++
 tb/tb_spi_slave.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI mode-3 target endpoint.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_t;

    localparam logic SPI_CLK_IDLE  = 1'b1;
    localparam logic SPI_MISO_IDLE = 1'b1;
    localparam int   BYTE_W        = 8;
    localparam int   CNT_W         = $clog2(BYTE_W);

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-3 target: oversamples the link in sys_clk, receives MSB-first
// bytes and transmits from a one-entry holding register.
module spi_slave
    import spi_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic       tx_underrun,
    output logic       busy
);

    spi_state_t              state, state_n;
    logic                    clk_lvl_unused, clk_rise, clk_fall;
    logic                    csn_s, csn_rise, csn_fall;
    logic [SYNC_STAGES-1:0]  mosi_q;
    logic                    mosi_s;
    logic [BYTE_W-1:0]       tx_shift, rx_shift, hold_q, load_byte, rx_next;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    first_byte;
    logic                    deselect, reload, shift_out, sample;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SPI_CLK_IDLE)) u_clk_sync (
        .sys_clk (sys_clk),
        .rst     (rst),
        .din     (spi_clk),
        .dout    (clk_lvl_unused),
        .rise    (clk_rise),
        .fall    (clk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
        .sys_clk (sys_clk),
        .rst     (rst),
        .din     (spi_csn),
        .dout    (csn_s),
        .rise    (csn_rise),
        .fall    (csn_fall)
    );

    // mosi has the same depth as spi_clk so data lines up with the rise pulse
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) mosi_q <= '1;
        else     mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    end

    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign busy      = ~csn_s;
    assign deselect  = (state != IDLE) && csn_rise;
    assign reload    = !deselect && ((state == LOAD) ||
                       (state == SHIFT && clk_fall && bit_cnt == '0 && !first_byte));
    assign shift_out = !deselect && state == SHIFT && clk_fall && bit_cnt != '0;
    assign sample    = !deselect && state == SHIFT && clk_rise;
    assign load_byte = tx_ready ? FILL_BYTE : hold_q;
    assign rx_next   = {rx_shift[BYTE_W-2:0], mosi_s};

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (csn_fall) state_n = LOAD;
            LOAD:    state_n = csn_rise ? IDLE : SHIFT;
            SHIFT:   if (csn_rise) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            spi_miso    <= SPI_MISO_IDLE;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b1;
            tx_underrun <= 1'b0;
            hold_q      <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            first_byte  <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            // A reload consumes the old holding content before a same-cycle write lands
            if (tx_load && (tx_ready || reload)) begin
                hold_q   <= tx_data;
                tx_ready <= 1'b0;
            end else if (reload) begin
                tx_ready <= 1'b1;
            end

            if (reload) begin
                tx_shift    <= load_byte;
                spi_miso    <= load_byte[BYTE_W-1];
                tx_underrun <= tx_ready;
            end else if (shift_out) begin
                tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                spi_miso <= tx_shift[BYTE_W-2];
            end

            if (state == LOAD) first_byte <= 1'b1;

            if (sample) begin
                rx_shift   <= rx_next;
                bit_cnt    <= bit_cnt + 1'b1;
                first_byte <= 1'b0;
                if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end
            end

            if (deselect) begin
                bit_cnt    <= '0;
                spi_miso   <= SPI_MISO_IDLE;
                first_byte <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as a mode-3 master with a 4-cycle half period.
module tb_spi_slave;

    localparam int HALF = 4;
    localparam int SYNC = 2;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_clk = 1'b1;
    logic       spi_csn = 1'b1;
    logic       spi_mosi = 1'b1;
    logic       spi_miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic       tx_underrun;
    logic       busy;

    spi_slave #(.SYNC_STAGES(SYNC), .FILL_BYTE(8'hFF)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .spi_clk     (spi_clk),
        .spi_csn     (spi_csn),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int         checks = 0;
    int         errors = 0;
    int         rxv_cnt = 0;
    int         und_cnt = 0;
    logic [7:0] rx_last = 8'h00;

    always @(negedge sys_clk) begin
        if (rx_valid) begin
            rxv_cnt = rxv_cnt + 1;
            rx_last = rx_data;
        end
        if (tx_underrun) und_cnt = und_cnt + 1;
    end

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] txd;
        logic       pre;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_und;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic load_tx(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        wait_n(1);
        tx_load = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_clk  = 1'b0;
            spi_mosi = mo[7-i];
            wait_n(HALF);
            spi_clk   = 1'b1;
            mi[7-i]   = spi_miso;
            wait_n(HALF);
        end
    endtask

    task automatic select_dut();
        spi_csn = 1'b0;
        wait_n(6);
    endtask

    task automatic deselect_dut();
        spi_csn = 1'b1;
        wait_n(8);
    endtask

    initial begin
        logic [7:0] m1, m2;
        int r0, u0;

        vecs[0] = '{mosi: 8'h3C, txd: 8'hA5, pre: 1'b1, exp_rx: 8'h3C, exp_miso: 8'hA5, exp_und: 0};
        vecs[1] = '{mosi: 8'h96, txd: 8'h00, pre: 1'b0, exp_rx: 8'h96, exp_miso: 8'hFF, exp_und: 1};
        vecs[2] = '{mosi: 8'h00, txd: 8'h7E, pre: 1'b1, exp_rx: 8'h00, exp_miso: 8'h7E, exp_und: 0};

        wait_n(3);
        check("rst_miso", spi_miso, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_underrun", tx_underrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        wait_n(4);

        for (int v = 0; v < 3; v++) begin
            r0 = rxv_cnt;
            u0 = und_cnt;
            if (vecs[v].pre) begin
                load_tx(vecs[v].txd);
                check($sformatf("vec%0d_tx_ready_full", v), tx_ready, 1'b0);
            end
            select_dut();
            check($sformatf("vec%0d_busy", v), busy, 1'b1);
            check($sformatf("vec%0d_tx_ready_load", v), tx_ready, 1'b1);
            spi_bits(vecs[v].mosi, 8, m1);
            deselect_dut();
            check($sformatf("vec%0d_rx_pulses", v), rxv_cnt - r0, 1);
            check($sformatf("vec%0d_rx_data", v), rx_last, vecs[v].exp_rx);
            check($sformatf("vec%0d_miso_byte", v), m1, vecs[v].exp_miso);
            check($sformatf("vec%0d_underruns", v), und_cnt - u0, vecs[v].exp_und);
            check($sformatf("vec%0d_miso_idle", v), spi_miso, 1'b1);
        end

        // back-to-back bytes, second TX byte queued once the first has been taken
        r0 = rxv_cnt;
        u0 = und_cnt;
        load_tx(8'h55);
        select_dut();
        load_tx(8'hAA);
        check("b2b_tx_ready_after_load", tx_ready, 1'b0);
        spi_bits(8'h01, 8, m1);
        check("b2b_rx_first", rx_last, 8'h01);
        spi_bits(8'h80, 8, m2);
        deselect_dut();
        check("b2b_miso_first", m1, 8'h55);
        check("b2b_miso_second", m2, 8'hAA);
        check("b2b_rx_pulses", rxv_cnt - r0, 2);
        check("b2b_rx_second", rx_last, 8'h80);
        check("b2b_underruns", und_cnt - u0, 0);
        check("b2b_tx_ready_end", tx_ready, 1'b1);

        // write while full is dropped
        load_tx(8'h22);
        load_tx(8'h11);
        check("ign_tx_ready", tx_ready, 1'b0);
        select_dut();
        spi_bits(8'h0F, 8, m1);
        deselect_dut();
        check("ign_miso_byte", m1, 8'h22);
        check("ign_rx_data", rx_last, 8'h0F);
        check("ign_tx_ready_end", tx_ready, 1'b1);

        // deselect after 5 bits
        r0 = rxv_cnt;
        load_tx(8'h00);
        select_dut();
        spi_bits(8'hF0, 5, m1);
        check("part_miso_low", spi_miso, 1'b0);
        spi_csn = 1'b1;
        wait_n(SYNC + 2);
        check("part_miso_idle", spi_miso, 1'b1);
        wait_n(4);
        check("part_no_rx", rxv_cnt - r0, 0);
        check("part_busy", busy, 1'b0);
        select_dut();
        spi_bits(8'hC3, 8, m1);
        deselect_dut();
        check("part_next_pulses", rxv_cnt - r0, 1);
        check("part_next_rx", rx_last, 8'hC3);

        // reset in the middle of a frame
        load_tx(8'h18);
        select_dut();
        spi_bits(8'hA0, 3, m1);
        check("mid_miso_before", spi_miso, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_miso", spi_miso, 1'b1);
        check("mid_rst_rx_data", rx_data, 8'h00);
        check("mid_rst_rx_valid", rx_valid, 1'b0);
        check("mid_rst_tx_ready", tx_ready, 1'b1);
        check("mid_rst_underrun", tx_underrun, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        spi_csn = 1'b1;
        spi_clk = 1'b1;
        wait_n(2);
        rst = 1'b0;
        wait_n(6);
        r0 = rxv_cnt;
        u0 = und_cnt;
        select_dut();
        spi_bits(8'h5A, 8, m1);
        deselect_dut();
        check("post_rst_pulses", rxv_cnt - r0, 1);
        check("post_rst_rx", rx_last, 8'h5A);
        check("post_rst_miso_fill", m1, 8'hFF);
        check("post_rst_underruns", und_cnt - u0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
